score_flash_sequencer: RTL

- Upstream master of the flash bridge; the bridge is the raw single-byte flash access stage.
- On request, saves a snapshot of the scoreboard's score bytes into flash as one framed record: magic byte, score bytes, checksum byte.
- On request, reads the record back, validates it, and presents the scores to the scoreboard.
- Issues one bridge access at a time over the bridge's start/done handshake.

---
 rtl/score_flash_sequencer_pkg.sv | 23 ++
 rtl/score_flash_sequencer_timer.sv | 29 ++
 rtl/score_flash_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/score_flash_sequencer_pkg.sv
// Shared constants for the score flash sequencer: FSM encoding, record
// offsets and bridge direction codes.
package score_flash_sequencer_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_NEXT    = 3'd4;
  localparam logic [2:0] ST_CHECK   = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam int MAGIC_OFS = 0;

  localparam logic DIR_READ  = 1'b1;
  localparam logic DIR_WRITE = 1'b0;

  // Checksum sits right after the last score byte.
  function automatic int csum_ofs(input int num_bytes);
    return num_bytes + 1;
  endfunction

endpackage

// File: rtl/score_flash_sequencer_timer.sv
// Per-access bridge timeout counter: cleared on issue, counts while waiting,
// flags expiry on the TIMEOUT_CYCLES-th waiting cycle.
module bridge_access_timer #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic CLK_50MHZ,
  input  logic RST_N,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = enable && (count_reg == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/score_flash_sequencer.sv
// Saves / restores a framed score record (magic, scores, checksum) through a
// single-byte flash bridge, one start/done access at a time.
module score_flash_sequencer
  import score_flash_sequencer_pkg::*;
#(
  parameter int         NUM_BYTES      = 4,
  parameter logic [7:0] MAGIC          = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1023
) (
  input  logic                   CLK_50MHZ,
  input  logic                   RST_N,
  input  logic                   save_req,
  input  logic                   load_req,
  input  logic [7:0]             base_addr,
  input  logic [8*NUM_BYTES-1:0] score_in,
  output logic [8*NUM_BYTES-1:0] score_out,
  output logic                   busy,
  output logic                   op_done,
  output logic                   load_err,
  output logic                   timeout_err,
  output logic [7:0]             addr,
  output logic [7:0]             wr_data,
  input  logic [7:0]             rd_data,
  output logic                   direction_rw,
  output logic                   fb_start,
  input  logic                   fb_done
);

  localparam int CSUM_OFS = csum_ofs(NUM_BYTES);
  localparam int REC_LEN  = NUM_BYTES + 2;
  localparam int KW       = $clog2(REC_LEN);

  logic [2:0]             state_reg;
  logic [KW-1:0]          k_reg;
  logic [7:0]             base_reg;
  logic                   is_load_reg;
  logic [7:0]             rec_reg [0:REC_LEN-1];
  logic [8*NUM_BYTES-1:0] score_out_reg;
  logic                   load_err_reg;
  logic                   timeout_err_reg;

  logic [8*NUM_BYTES-1:0] rec_scores;
  logic [7:0]             save_csum;
  logic [7:0]             load_csum;
  logic                   timer_expired;
  logic                   k_last;

  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_rec_scores
      assign rec_scores[8*gi +: 8] = rec_reg[1+gi];
    end
  endgenerate

  always_comb begin
    save_csum = MAGIC;
    load_csum = MAGIC;
    for (int i = 0; i < NUM_BYTES; i++) begin
      save_csum = save_csum + score_in[8*i +: 8];
      load_csum = load_csum + rec_reg[1+i];
    end
  end

  assign k_last = (k_reg == KW'(CSUM_OFS));

  bridge_access_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .CLK_50MHZ(CLK_50MHZ),
    .RST_N    (RST_N),
    .clear    (state_reg == ST_ISSUE),
    .enable   (state_reg == ST_WAIT),
    .expired  (timer_expired)
  );

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_reg       <= ST_IDLE;
      k_reg           <= '0;
      base_reg        <= '0;
      is_load_reg     <= 1'b0;
      score_out_reg   <= '0;
      load_err_reg    <= 1'b0;
      timeout_err_reg <= 1'b0;
      for (int i = 0; i < REC_LEN; i++) rec_reg[i] <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (save_req || load_req) begin
            base_reg        <= base_addr;
            is_load_reg     <= !save_req;
            k_reg           <= '0;
            load_err_reg    <= 1'b0;
            timeout_err_reg <= 1'b0;
            if (save_req) begin
              rec_reg[MAGIC_OFS] <= MAGIC;
              for (int i = 0; i < NUM_BYTES; i++) rec_reg[1+i] <= score_in[8*i +: 8];
              rec_reg[CSUM_OFS] <= save_csum;
            end
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_reg <= ST_WAIT;
        ST_WAIT: begin
          if (fb_done) begin
            state_reg <= is_load_reg ? ST_CAPTURE : ST_NEXT;
          end else if (timer_expired) begin
            timeout_err_reg <= 1'b1;
            state_reg       <= ST_DONE;
          end
        end
        ST_CAPTURE: begin
          rec_reg[k_reg] <= rd_data;
          state_reg      <= ST_NEXT;
        end
        ST_NEXT: begin
          if (k_last) begin
            state_reg <= is_load_reg ? ST_CHECK : ST_DONE;
          end else begin
            k_reg     <= k_reg + 1'b1;
            state_reg <= ST_ISSUE;
          end
        end
        ST_CHECK: begin
          // Only a fully consistent record may overwrite the published scores.
          if (rec_reg[MAGIC_OFS] == MAGIC && rec_reg[CSUM_OFS] == load_csum) begin
            score_out_reg <= rec_scores;
          end else begin
            load_err_reg <= 1'b1;
          end
          state_reg <= ST_DONE;
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Bridge-side outputs derive from state held constant across an access.
  assign addr         = base_reg + 8'(k_reg);
  assign wr_data      = rec_reg[k_reg];
  assign direction_rw = is_load_reg ? DIR_READ : DIR_WRITE;
  assign fb_start     = (state_reg == ST_ISSUE);
  assign busy         = (state_reg != ST_IDLE);
  assign op_done      = (state_reg == ST_DONE);
  assign score_out    = score_out_reg;
  assign load_err     = load_err_reg;
  assign timeout_err  = timeout_err_reg;

endmodule
